// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: ROM read port, redirect
// from execute, and decode handshake.
interface if_fetch_queue_if;
    logic [31:0] o_rom_addr;
    logic [31:0] i_rom_data;
    logic [31:0] i_rom_addr;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;

    modport master (
        output o_rom_addr,
        input  i_rom_data,
        input  i_rom_addr,
        input  i_redirect,
        input  i_redirect_pc,
        output o_valid,
        input  i_ready,
        output o_inst,
        output o_pc
    );

    modport slave (
        input  o_rom_addr,
        output i_rom_data,
        output i_rom_addr,
        output i_redirect,
        output i_redirect_pc,
        input  o_valid,
        output i_ready,
        input  o_inst,
        input  o_pc
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch: issues sequential ROM reads
// and buffers responses in a 2-entry queue.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic i_Clk,
    input  logic i_reset_n,
    if_fetch_queue_if.master bus
);
    logic [31:0] pc_q;
    logic        in_flight_q;
    logic [31:0] inst_mem [2];
    logic [31:0] pc_mem [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;

    logic        valid;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  pending;

    assign valid = (count_q != 2'd0);
    assign pop   = valid & bus.i_ready;
    assign push  = in_flight_q & ~bus.i_redirect;

    // Words owed to decode after this cycle's pop;
    // at most one may be outstanding when issuing.
    assign pending = {1'b0, count_q}
                   + {2'b00, in_flight_q}
                   - {2'b00, pop};
    assign issue = ~bus.i_redirect
                 & (pending <= 3'd1);

    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q        <= RESET_PC;
            in_flight_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                inst_mem[i] <= 32'd0;
                pc_mem[i]   <= 32'd0;
            end
        end else if (bus.i_redirect) begin
            pc_q        <= bus.i_redirect_pc
                         & 32'hFFFF_FFFC;
            in_flight_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
            in_flight_q <= issue;
            if (push) begin
                inst_mem[wr_ptr_q] <= bus.i_rom_data;
                pc_mem[wr_ptr_q]   <= bus.i_rom_addr;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q
                     + {1'b0, push}
                     - {1'b0, pop};
        end
    end

    assign bus.o_rom_addr = pc_q;
    assign bus.o_valid    = valid;
    assign bus.o_inst     = valid
                          ? inst_mem[rd_ptr_q]
                          : 32'd0;
    assign bus.o_pc       = valid
                          ? pc_mem[rd_ptr_q]
                          : 32'd0;
endmodule
